// File: rtl/seq_sum.sv
// ============================================================================
// Module  : seq_sum
// Brief   : Serial summer. Takes NADDENDS addends over a valid/ready stream
//           and returns their sum mod 2^NBITS over a valid/ready handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_sum #(
  parameter int NBITS    = 3,
  parameter int NADDENDS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [NBITS-1:0] in_data,
  output logic             in_ready,
  input  logic             out_ready,
  output logic [NBITS-1:0] sum,
  output logic             sum_valid,
  output logic             busy
);

  localparam int c_CNT_W = (NADDENDS < 1) ? 1 : $clog2(NADDENDS + 1);
  // With NADDENDS==0 the ACCUM state is never entered, so c_LAST is unused.
  localparam logic [c_CNT_W-1:0] c_LAST =
    (NADDENDS == 0) ? '0 : c_CNT_W'(NADDENDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NBITS-1:0]   r_acc;
  logic [NBITS-1:0]   w_acc_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               w_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_xfer      = in_valid && (r_state == S_ACCUM);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = (NADDENDS == 0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        // in_data is only looked at on a transfer, so X while idle is harmless.
        if (w_xfer) begin
          w_acc_nxt = r_acc + in_data;
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
          if (r_cnt == c_LAST) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign in_ready  = (r_state == S_ACCUM);
  assign sum_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign sum       = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_seq_sum.sv
// ============================================================================
// Module  : tb_seq_sum
// Brief   : Self-checking bench for seq_sum: vector table, corner sequences,
//           parameter sweep and randomized sums against a reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_sum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // DUT A: NBITS=3, NADDENDS=6
  logic       a_start = 0, a_in_valid = 0, a_out_ready = 0;
  logic [2:0] a_in_data = '0;
  logic       a_in_ready, a_sum_valid, a_busy;
  logic [2:0] a_sum;
  seq_sum #(.NBITS(3), .NADDENDS(6)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_in_valid),
    .in_data(a_in_data), .in_ready(a_in_ready), .out_ready(a_out_ready),
    .sum(a_sum), .sum_valid(a_sum_valid), .busy(a_busy));

  // DUT B: NBITS=3, NADDENDS=1
  logic       b_start = 0, b_in_valid = 0, b_out_ready = 0;
  logic [2:0] b_in_data = '0;
  logic       b_in_ready, b_sum_valid, b_busy;
  logic [2:0] b_sum;
  seq_sum #(.NBITS(3), .NADDENDS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid),
    .in_data(b_in_data), .in_ready(b_in_ready), .out_ready(b_out_ready),
    .sum(b_sum), .sum_valid(b_sum_valid), .busy(b_busy));

  // DUT C: NBITS=3, NADDENDS=0
  logic       c_start = 0, c_in_valid = 0, c_out_ready = 0;
  logic [2:0] c_in_data = '0;
  logic       c_in_ready, c_sum_valid, c_busy;
  logic [2:0] c_sum;
  seq_sum #(.NBITS(3), .NADDENDS(0)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .in_valid(c_in_valid),
    .in_data(c_in_data), .in_ready(c_in_ready), .out_ready(c_out_ready),
    .sum(c_sum), .sum_valid(c_sum_valid), .busy(c_busy));

  // DUT R: NBITS=5, NADDENDS=7 (randomized)
  logic       r_start = 0, r_in_valid = 0, r_out_ready = 0;
  logic [4:0] r_in_data = '0;
  logic       r_in_ready, r_sum_valid, r_busy;
  logic [4:0] r_sum;
  seq_sum #(.NBITS(5), .NADDENDS(7)) u_r (
    .clk(clk), .rst_n(rst_n), .start(r_start), .in_valid(r_in_valid),
    .in_data(r_in_data), .in_ready(r_in_ready), .out_ready(r_out_ready),
    .sum(r_sum), .sum_valid(r_sum_valid), .busy(r_busy));

  typedef struct packed {
    logic [17:0] a;     // addend i in bits [3*i +: 3]
    logic [3:0]  gap;   // idle in_valid cycles before each addend
    logic [2:0]  exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full sum on DUT A; hold>0 stalls in DONE with start toggling, then
  // releases with start and out_ready high together.
  task automatic run_a(input vec_t v, input int hold);
    logic [17:0] all;
    all = v.a;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("a_accum_ready", 32'(a_in_ready), 32'd1);
    chk("a_accum_busy", 32'(a_busy), 32'd1);
    for (int i = 0; i < 6; i++) begin
      for (int g = 0; g < int'(v.gap); g++) begin
        a_in_valid = 1'b0;
        a_in_data  = 'x;
        tick();
        chk("a_gap_ready", 32'(a_in_ready), 32'd1);
        chk("a_gap_valid", 32'(a_sum_valid), 32'd0);
      end
      a_in_valid = 1'b1;
      a_in_data  = all[3*i +: 3];
      tick();
      a_in_valid = 1'b0;
      a_in_data  = 'x;
      chk("a_valid_timing", 32'(a_sum_valid), (i == 5) ? 32'd1 : 32'd0);
      chk("a_busy", 32'(a_busy), 32'd1);
    end
    chk("a_sum", 32'(a_sum), 32'(v.exp));
    chk("a_done_ready", 32'(a_in_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      a_out_ready = 1'b0;
      a_start     = k[0];
      tick();
      chk("a_hold_valid", 32'(a_sum_valid), 32'd1);
      chk("a_hold_sum", 32'(a_sum), 32'(v.exp));
    end
    a_out_ready = 1'b1;
    a_start     = (hold > 0);
    tick();
    a_out_ready = 1'b0;
    a_start     = 1'b0;
    chk("a_idle_valid", 32'(a_sum_valid), 32'd0);
    chk("a_idle_busy", 32'(a_busy), 32'd0);
    chk("a_idle_ready", 32'(a_in_ready), 32'd0);
    chk("a_idle_sum_kept", 32'(a_sum), 32'(v.exp));
    tick();
    chk("a_idle_stays", 32'(a_busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  q [$];
    int          mphase;
    int          done_sums;
    int          cyc;
    int unsigned s;

    vecs[0] = '{a: {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, gap: 4'd0, exp: 3'd5};
    vecs[1] = '{a: {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, gap: 4'd2, exp: 3'd5};
    vecs[2] = '{a: {3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7}, gap: 4'd0, exp: 3'd2};
    vecs[3] = '{a: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, gap: 4'd1, exp: 3'd0};
    vecs[4] = '{a: {3'd3, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1}, gap: 4'd0, exp: 3'd0};
    vecs[5] = '{a: {3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, gap: 4'd3, exp: 3'd3};

    a_in_data = 'x;
    #12;
    chk("rst_ready", 32'(a_in_ready), 32'd0);
    chk("rst_sum", 32'(a_sum), 32'd0);
    chk("rst_valid", 32'(a_sum_valid), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    for (int v = 0; v < 6; v++) begin
      run_a(vecs[v], (v == 0) ? 5 : 0);
    end

    // Reset in the middle of a sum: outputs drop without any clock edge.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 3'(i);
      tick();
    end
    a_in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", 32'(a_sum), 32'd0);
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    chk("mid_rst_ready", 32'(a_in_ready), 32'd0);
    chk("mid_rst_valid", 32'(a_sum_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_a(vecs[2], 0);

    // NADDENDS=1: result one edge after the single transfer.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("b_ready", 32'(b_in_ready), 32'd1);
    b_in_valid = 1'b1;
    b_in_data  = 3'd3;
    tick();
    b_in_valid = 1'b0;
    chk("b_valid", 32'(b_sum_valid), 32'd1);
    chk("b_sum", 32'(b_sum), 32'd3);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    chk("b_idle", 32'(b_busy), 32'd0);

    // NADDENDS=0: start goes straight to a zero result.
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    chk("c_valid", 32'(c_sum_valid), 32'd1);
    chk("c_sum", 32'(c_sum), 32'd0);
    chk("c_ready", 32'(c_in_ready), 32'd0);
    c_out_ready = 1'b1;
    tick();
    c_out_ready = 1'b0;
    chk("c_idle", 32'(c_busy), 32'd0);

    // Randomized sums; reference keeps the accepted addends and sums them.
    mphase    = 0;  // 0 waiting for start, 1 collecting, 2 holding result
    done_sums = 0;
    cyc       = 0;
    while (done_sums < 1000 && cyc < 80000) begin
      r_start     = 1'($urandom_range(0, 1));
      r_in_valid  = ($urandom_range(0, 3) != 0);
      r_in_data   = r_in_valid ? 5'($urandom) : 'x;
      r_out_ready = 1'($urandom_range(0, 1));
      case (mphase)
        0: if (r_start) begin
             q.delete();
             mphase = 1;
           end
        1: if (r_in_valid) begin
             q.push_back(r_in_data);
             if (q.size() == 7) mphase = 2;
           end
        default: if (r_out_ready) begin
             mphase = 0;
             done_sums++;
           end
      endcase
      tick();
      cyc++;
      chk("r_in_ready", 32'(r_in_ready), (mphase == 1) ? 32'd1 : 32'd0);
      chk("r_sum_valid", 32'(r_sum_valid), (mphase == 2) ? 32'd1 : 32'd0);
      chk("r_busy", 32'(r_busy), (mphase != 0) ? 32'd1 : 32'd0);
      if (mphase == 2) begin
        s = 0;
        foreach (q[k]) s += 32'(q[k]);
        chk("r_sum", 32'(r_sum), s % 32);
      end
    end
    r_start     = 1'b0;
    r_in_valid  = 1'b0;
    r_out_ready = 1'b0;
    chk("r_sum_count", 32'(done_sums), 32'd1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
